uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/uart_receiver.sv | 102 ++++++++++
 tb/tb_uart_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing derivation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLOCK_FREQUENCY = 50000000;
    localparam int DEFAULT_BAUD_RATE       = 115200;

    function automatic int clocks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    function automatic int half_bit(input int clock_frequency, input int baud_rate);
        return (clock_frequency / baud_rate) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= RESET_VALUE;
            o_q    <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, LSB-first assembly and framing check.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
    parameter int BAUD_RATE       = DEFAULT_BAUD_RATE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] char_data,
    output logic       char_ready,
    output logic       framing_error
);

    localparam int          CLOCKS_PER_BIT = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int          HALF_BIT       = half_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam logic [15:0] BIT_LOAD       = 16'(CLOCKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LOAD      = 16'(HALF_BIT - 1);

    logic        w_rx_s;
    logic        w_tick;
    logic        r_rx_prev;
    uart_state_t r_state;
    logic [15:0] r_count;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .i_d  (rx),
        .o_q  (w_rx_s)
    );

    assign w_tick = (r_count == 16'd0);

    // Only a high-to-low edge starts a frame, so a held-low line (break) stays idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_count       <= 16'd0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'h00;
            r_rx_prev     <= 1'b1;
            char_data     <= 8'h00;
            char_ready    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_rx_prev     <= w_rx_s;
            char_ready    <= 1'b0;
            framing_error <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_count <= HALF_LOAD;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_count <= r_count - 16'd1;
                    end else if (!w_rx_s) begin
                        r_count   <= BIT_LOAD;
                        r_bit_idx <= 3'd0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_count <= r_count - 16'd1;
                    end else begin
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_count   <= BIT_LOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (!w_tick) begin
                        r_count <= r_count - 16'd1;
                    end else begin
                        if (w_rx_s) begin
                            char_data  <= r_shift;
                            char_ready <= 1'b1;
                        end else begin
                            framing_error <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 50 MHz / 115200 baud (434 clocks per bit).
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CPB     = 434;
    localparam int LATENCY = 4126;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] char_data;
    logic       char_ready;
    logic       framing_error;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rdy_cnt = 0;
    int fe_cnt  = 0;
    int overlap_cnt = 0;
    logic [7:0] rdy_data [256];
    int         rdy_cyc  [256];
    logic [7:0] exp_last = 8'h00;

    uart_receiver #(
        .CLOCK_FREQUENCY(50000000),
        .BAUD_RATE      (115200)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .char_data    (char_data),
        .char_ready   (char_ready),
        .framing_error(framing_error)
    );

    always #10 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            if (char_ready) begin
                rdy_data[rdy_cnt % 256] <= char_data;
                rdy_cyc[rdy_cnt % 256]  <= cyc;
                rdy_cnt <= rdy_cnt + 1;
            end
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (char_ready && framing_error) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int period,
                              output int t0);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (period) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL reset_char_data got %h want 00", char_data); end
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL reset_char_ready got %b want 0", char_ready); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_framing_error got %b want 0", framing_error); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.r_state, ST_IDLE); end
        reset = 1'b1;
        idle(20);
    endtask

    task automatic test_single();
        int base, fbase, t0;
        base = rdy_cnt; fbase = fe_cnt;
        send_frame(8'h53, 1'b1, CPB, t0);
        idle(200);
        checks++; if (rdy_cnt - base !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rdy_cnt - base); end
        checks++; if (rdy_data[base] !== 8'h53) begin errors++; $display("FAIL single_data got %h want 53", rdy_data[base]); end
        checks++; if (fe_cnt !== fbase) begin errors++; $display("FAIL single_fe got %0d want %0d", fe_cnt, fbase); end
        checks++; if (rdy_cyc[base] - t0 !== LATENCY) begin errors++; $display("FAIL single_latency got %0d want %0d", rdy_cyc[base] - t0, LATENCY); end
        exp_last = 8'h53;
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [4];
        int base, t0;
        msg[0] = 8'h53; msg[1] = 8'h33; msg[2] = 8'h0D; msg[3] = 8'h0A;
        base = rdy_cnt;
        for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1, CPB, t0);
        idle(200);
        checks++; if (rdy_cnt - base !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", rdy_cnt - base); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdy_data[base + i] !== msg[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, rdy_data[base + i], msg[i]); end
        end
        for (int i = 1; i < 4; i++) begin
            checks++; if (rdy_cyc[base + i] - rdy_cyc[base + i - 1] !== 10 * CPB) begin
                errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, rdy_cyc[base + i] - rdy_cyc[base + i - 1], 10 * CPB);
            end
        end
        exp_last = 8'h0A;
    endtask

    task automatic test_glitch();
        int base, fbase;
        base = rdy_cnt; fbase = fe_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clock);
        idle(1000);
        checks++; if (rdy_cnt !== base) begin errors++; $display("FAIL glitch_ready got %0d want %0d", rdy_cnt, base); end
        checks++; if (fe_cnt !== fbase) begin errors++; $display("FAIL glitch_fe got %0d want %0d", fe_cnt, fbase); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL glitch_state got %0d want %0d", dut.r_state, ST_IDLE); end
    endtask

    task automatic test_framing();
        int base, fbase, t0;
        base = rdy_cnt; fbase = fe_cnt;
        send_frame(8'hA5, 1'b0, CPB, t0);
        rx = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        idle(1000);
        checks++; if (fe_cnt - fbase !== 1) begin errors++; $display("FAIL break_fe_count got %0d want 1", fe_cnt - fbase); end
        checks++; if (rdy_cnt !== base) begin errors++; $display("FAIL break_ready got %0d want %0d", rdy_cnt, base); end
        checks++; if (char_data !== exp_last) begin errors++; $display("FAIL break_char_data got %h want %h", char_data, exp_last); end
        send_frame(8'h41, 1'b1, CPB, t0);
        idle(200);
        checks++; if (rdy_cnt - base !== 1) begin errors++; $display("FAIL after_break_count got %0d want 1", rdy_cnt - base); end
        checks++; if (rdy_data[base] !== 8'h41) begin errors++; $display("FAIL after_break_data got %h want 41", rdy_data[base]); end
        checks++; if (fe_cnt - fbase !== 1) begin errors++; $display("FAIL after_break_fe got %0d want 1", fe_cnt - fbase); end
        exp_last = 8'h41;
    endtask

    task automatic test_reset_abort();
        int base, fbase, t0;
        base = rdy_cnt; fbase = fe_cnt;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (4 * CPB + 200) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (char_data !== 8'h00) begin errors++; $display("FAIL abort_char_data got %h want 00", char_data); end
        reset = 1'b1;
        idle(5 * CPB);
        checks++; if (rdy_cnt !== base) begin errors++; $display("FAIL abort_ready got %0d want %0d", rdy_cnt, base); end
        checks++; if (fe_cnt !== fbase) begin errors++; $display("FAIL abort_fe got %0d want %0d", fe_cnt, fbase); end
        send_frame(8'h30, 1'b1, CPB, t0);
        idle(200);
        checks++; if (rdy_cnt - base !== 1) begin errors++; $display("FAIL abort_next_count got %0d want 1", rdy_cnt - base); end
        checks++; if (rdy_data[base] !== 8'h30) begin errors++; $display("FAIL abort_next_data got %h want 30", rdy_data[base]); end
    endtask

    task automatic test_rate_tolerance();
        int periods [2];
        int base, t0;
        periods[0] = 425; periods[1] = 443;
        for (int p = 0; p < 2; p++) begin
            base = rdy_cnt;
            send_frame(8'h55, 1'b1, periods[p], t0);
            idle(500);
            checks++; if (rdy_cnt - base !== 1) begin errors++; $display("FAIL rate%0d_count got %0d want 1", periods[p], rdy_cnt - base); end
            checks++; if (rdy_data[base] !== 8'h55) begin errors++; $display("FAIL rate%0d_data got %h want 55", periods[p], rdy_data[base]); end
        end
    endtask

    task automatic test_exclusive();
        checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL ready_fe_overlap got %0d want 0", overlap_cnt); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_abort();
        test_rate_tolerance();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
